// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: accepts PC-stage fetch addresses, reads a 1-cycle
// synchronous instruction RAM and returns words in order through a response FIFO.
module ifetch_resp #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                MEM_AW     = 10,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] NOP_INST   = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    input  logic              flush,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_err,
    input  logic              inst_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic              err;
    } entry_t;

    entry_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   occ;
    logic [CNT_W-1:0]   buf_cnt;
    logic               alive;
    logic               if_vld;
    logic               if_err;
    logic [ADDR_W-1:0]  if_addr;
    logic               accept, pop, req_aligned;

    // alive keeps req_ready low while reset is held and until the first edge after release
    assign req_aligned = (req_addr[1:0] == 2'b00);
    assign req_ready   = alive & (occ < CNT_W'(FIFO_DEPTH)) & ~flush;
    assign accept      = req_valid & req_ready;
    assign mem_en      = accept & req_aligned;
    assign mem_addr    = req_addr[MEM_AW+1:2];

    // Occupancy counts the in-flight slot too, so buffered entries exclude it.
    assign buf_cnt     = occ - CNT_W'(if_vld);
    assign inst_valid  = (buf_cnt != '0) & ~flush;
    assign pop         = inst_valid & inst_ready;
    assign inst_o      = fifo_q[rd_ptr].data;
    assign inst_addr_o = fifo_q[rd_ptr].addr;
    assign inst_err    = fifo_q[rd_ptr].err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive   <= 1'b0;
            occ     <= '0;
            if_vld  <= 1'b0;
            if_err  <= 1'b0;
            if_addr <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            alive <= 1'b1;
            if (flush) begin
                // in-flight read data is dropped; nothing from before the flush survives
                occ    <= '0;
                if_vld <= 1'b0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                occ    <= occ + CNT_W'(accept) - CNT_W'(pop);
                if_vld <= accept;
                if (accept) begin
                    if_addr <= req_addr;
                    if_err  <= ~req_aligned;
                end
                if (if_vld) begin
                    fifo_q[wr_ptr] <= '{data: (if_err ? NOP_INST : mem_rdata),
                                        addr: if_addr, err: if_err};
                    wr_ptr         <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: doc/ifetch_resp.md
Name: ifetch_resp

Overview:
- Instruction-fetch responder: the memory-side end of the PC fetch interface.
- Accepts fetch addresses from the PC stage over a valid/ready handshake and reads instruction words from a synchronous instruction RAM (1-cycle read latency).
- Returns instructions in order, with their addresses, to the decode stage through an in-order response FIFO.
- Supports branch/jump flush and decode-side hold (back-pressure).

Parameters:
- ADDR_W, 32, fetch address width in bits.
- DATA_W, 32, instruction width in bits.
- MEM_AW, 10, instruction RAM word-address width.
- FIFO_DEPTH, 4, maximum outstanding responses (in-flight plus buffered); power of two, minimum 2.
- NOP_INST, 32'h00000013, word returned for misaligned fetches.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst==0 resets).
- req_valid  input  1  PC stage presents a fetch address.
- req_addr  input  ADDR_W  byte address of the instruction to fetch.
- req_ready  output  1  responder can accept a request this cycle.
- flush  input  1  jump/branch taken; discard all outstanding fetches.
- mem_en  output  1  RAM read enable.
- mem_addr  output  MEM_AW  RAM word address, equal to req_addr[MEM_AW+1:2].
- mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en.
- inst_valid  output  1  response at FIFO head is available.
- inst_o  output  DATA_W  instruction word.
- inst_addr_o  output  ADDR_W  fetch address belonging to inst_o.
- inst_err  output  1  response came from a misaligned fetch.
- inst_ready  input  1  decode consumes the head; low means hold.

Behaviour:
- Reset (rst==0, asynchronous):
  - FIFO empties; occupancy counter goes to 0; in-flight stage is invalidated.
  - inst_valid=0, inst_o=0, inst_addr_o=0, inst_err=0, req_ready=0, mem_en=0.
  - req_ready may rise in the first cycle after rst returns high.
- Occupancy: count of accepted requests not yet popped, covering both in-flight and buffered entries.
- req_ready = (occupancy < FIFO_DEPTH) & ~flush. It has no combinational dependence on inst_ready.
- Accept: a request is accepted when req_valid & req_ready. The in-flight stage latches req_addr and err = (req_addr[1:0] != 0).
- mem_en = accept & aligned. Misaligned fetches never read the RAM.
- Cycle after accept (in-flight valid), one entry is written to the FIFO tail:
  - data = mem_rdata if aligned, otherwise NOP_INST;
  - address = latched address;
  - err = latched err flag.
- Pop: FIFO head is visible on inst_* in the cycle after the write. Minimum latency from request acceptance to inst_valid is 2 cycles.
- inst_valid = FIFO non-empty & ~flush. Pop on inst_valid & inst_ready.
- Occupancy update: +1 on accept, -1 on pop. Both in the same cycle leaves it unchanged.
- Hold: while inst_ready=0, the head stays stable (inst_o, inst_addr_o and inst_err do not change). Requests continue to be accepted until occupancy reaches FIFO_DEPTH. No entry is ever lost or overwritten.
- Sustained throughput is 1 instruction/cycle with inst_ready=1 and FIFO_DEPTH>=3. Order is strictly preserved, including a mix of aligned and misaligned fetches.
- Flush (one-cycle pulse or held):
  - In the flush cycle: req_ready=0 and inst_valid=0, so no accept and no pop.
  - At the clock edge: FIFO pointers reset, occupancy=0, in-flight stage invalidated. Its mem_rdata is discarded and never enters the FIFO.
  - The first cycle after flush deasserts, req_ready=1; the new target address is accepted normally.
- FIFO pointers wrap modulo FIFO_DEPTH. Full and empty are derived from occupancy, not from pointer equality alone.
- Simultaneous events:
  - flush plus a pending accept/pop: flush wins.
  - Full plus a pop in the same cycle: req_ready still 0 that cycle; accept resumes next cycle.
- Reset asserted mid-operation: all outstanding fetches are discarded exactly as on flush. Outputs go to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset then streaming: release rst, req_valid=1 with addresses 0x0,0x4,0x8,0xC, inst_ready=1, RAM words 0x11,0x22,0x33,0x44. Required: inst_valid first rises 2 cycles after the first accept; inst_o sequence 0x11,0x22,0x33,0x44 on consecutive cycles; inst_addr_o matches each fetch address.
- Hold/back-pressure: inst_ready=0 with continuous requests. Required: req_ready drops after exactly 4 accepts; the head stays 0x11/0x0. Release inst_ready: all 4 pop in order, and req_ready reasserts in the cycle after the first pop.
- Flush: 3 outstanding fetches (0x10,0x14,0x18), then flush=1 for one cycle, then request 0x40 (RAM word 0xAB). Required: none of the first three responses appear; the next inst_valid carries inst_o=0xAB, inst_addr_o=0x40.
- Misaligned fetch: requests 0x20, 0x22, 0x24. Required: mem_en low for 0x22; responses are RAM[0x20], 0x00000013 with inst_err=1, then RAM[0x24], in that order.
- Async reset mid-stream: assert rst low between clock edges with 2 entries buffered. Required: inst_valid and req_ready go to 0 immediately. After release, no stale entry appears; occupancy restarts at 0.
